// File: rtl/snn_pkg.sv
// snn_pkg: shared types, constants and helpers for the spiking datapath.
package snn_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [31:0] FIRST_NONE = '1;

    // Clamp v to the signed range of a w-bit value.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/lif_channel.sv
// lif_channel: one leaky integrate-and-fire neuron with refractory period,
// saturating spike count and first-spike time.
module lif_channel
    import snn_pkg::*;
#(
    parameter int W_IN       = 16,
    parameter int W_POT      = 24,
    parameter int THRESH     = 1000,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int W_CNT      = 8,
    parameter int W_T        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step_i,
    input  logic                   clear_i,
    input  logic [W_T-1:0]         step_idx_i,
    input  logic signed [W_IN-1:0] in_i,
    output logic                   spike_o,
    output logic [W_CNT-1:0]       cnt_o,
    output logic [W_T-1:0]         first_o
);
    localparam int W_R = $clog2(REFRAC + 2);

    logic signed [W_POT-1:0] pot_q, pot_d;
    logic [W_R-1:0]          ref_q, ref_d;
    logic [W_CNT-1:0]        cnt_q, cnt_d;
    logic [W_T-1:0]          first_q, first_d;
    logic                    spike_q, spike_d;
    logic signed [W_POT+1:0] p_wide;
    logic signed [63:0]      p_sat;
    logic                    fire;

    always_comb begin
        p_wide  = (W_POT+2)'(pot_q) - ((W_POT+2)'(pot_q) >>> LEAK_SHIFT) + (W_POT+2)'(in_i);
        p_sat   = saturate(64'(p_wide), W_POT);
        fire    = (ref_q == '0) && (p_sat >= 64'(THRESH));
        pot_d   = pot_q;
        ref_d   = ref_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        spike_d = 1'b0;
        if (clear_i) begin
            pot_d   = '0;
            ref_d   = '0;
            cnt_d   = '0;
            first_d = FIRST_NONE[W_T-1:0];
        end else if (step_i) begin
            if (ref_q != '0) begin
                ref_d = ref_q - 1'b1;
            end else if (fire) begin
                spike_d = 1'b1;
                pot_d   = '0;
                ref_d   = W_R'(REFRAC);
                cnt_d   = cnt_q + W_CNT'(cnt_q != '1);
                first_d = (first_q == FIRST_NONE[W_T-1:0]) ? step_idx_i : first_q;
            end else begin
                pot_d = p_sat[W_POT-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pot_q   <= '0;
            ref_q   <= '0;
            cnt_q   <= '0;
            first_q <= FIRST_NONE[W_T-1:0];
            spike_q <= 1'b0;
        end else begin
            pot_q   <= pot_d;
            ref_q   <= ref_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;
    assign cnt_o   = cnt_q;
    assign first_o = first_q;

endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: window sequencer plus N_CH parallel LIF neurons reporting
// per-channel spike counts and first-spike times.
module lif_neuron_array
    import snn_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int W_IN       = 16,
    parameter int W_POT      = 24,
    parameter int THRESH     = 1000,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int T_WINDOW   = 250,
    parameter int W_CNT      = 8,
    parameter int W_T        = $clog2(T_WINDOW + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  en,
    input  logic [N_CH*W_IN-1:0]  in_value,
    output logic [N_CH-1:0]       out_spike,
    output logic [N_CH*W_CNT-1:0] spike_cnt,
    output logic [N_CH*W_T-1:0]   first_time,
    output logic                  busy,
    output logic                  window_done
);
    state_e         state_q, state_d;
    logic [W_T-1:0] step_q, step_d;
    logic           done_q, done_d;
    logic           clear, step, last;

    always_comb begin
        clear   = start && (state_q != RUN);
        step    = (state_q == RUN) && en;
        last    = step && (step_q == W_T'(T_WINDOW - 1));
        state_d = clear ? RUN : last ? DONE : state_q;
        step_d  = clear ? '0 : step ? step_q + 1'b1 : step_q;
        done_d  = last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign window_done = done_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        lif_channel #(
            .W_IN(W_IN), .W_POT(W_POT), .THRESH(THRESH), .LEAK_SHIFT(LEAK_SHIFT),
            .REFRAC(REFRAC), .W_CNT(W_CNT), .W_T(W_T)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .step_i    (step),
            .clear_i   (clear),
            .step_idx_i(step_q),
            .in_i      (in_value[g*W_IN +: W_IN]),
            .spike_o   (out_spike[g]),
            .cnt_o     (spike_cnt[g*W_CNT +: W_CNT]),
            .first_o   (first_time[g*W_T +: W_T])
        );
    end

endmodule
